// File: rtl/sd_block_writer_if.sv
// Handshake bundle between the block writer, its command source, the frame-buffer
// read port and the shared SPI byte engine.
interface sd_block_writer_if;
  logic        start;
  logic [31:0] block_addr;
  logic [16:0] pixel_base;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;
  logic        cs;
  logic [16:0] pixel_addr;
  logic [7:0]  pixel_rd_data;
  logic        spi_start;
  logic [7:0]  spi_data_in;
  logic        spi_done;
  logic [7:0]  spi_data_out;

  modport master (
    input  start, block_addr, pixel_base, pixel_rd_data, spi_done, spi_data_out,
    output busy, done, error, err_code, cs, pixel_addr, spi_start, spi_data_in
  );

  modport slave (
    output start, block_addr, pixel_base, pixel_rd_data, spi_done, spi_data_out,
    input  busy, done, error, err_code, cs, pixel_addr, spi_start, spi_data_in
  );
endinterface

// File: rtl/sd_block_writer.sv
// SD card single-block writer (CMD24, SPI mode): streams one block out of the frame
// buffer to the card through the shared byte-level SPI engine.
module sd_block_writer #(
  parameter int BLOCK_BYTES = 512,
  parameter int R1_POLLS    = 8,
  parameter int DRESP_POLLS = 8,
  parameter int BUSY_POLLS  = 65535
) (
  input logic               clk,
  input logic               reset,
  sd_block_writer_if.master bus
);
  localparam int CNT_W  = $clog2(BLOCK_BYTES) + 1;
  localparam int POLL_W = $clog2(BUSY_POLLS + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_CMD   = 4'd1;
  localparam logic [3:0] S_R1    = 4'd2;
  localparam logic [3:0] S_GAP   = 4'd3;
  localparam logic [3:0] S_TOKEN = 4'd4;
  localparam logic [3:0] S_DATA  = 4'd5;
  localparam logic [3:0] S_CRC   = 4'd6;
  localparam logic [3:0] S_DRESP = 4'd7;
  localparam logic [3:0] S_BUSYW = 4'd8;
  localparam logic [3:0] S_FIN   = 4'd9;
  localparam logic [3:0] S_FAIL  = 4'd10;

  logic [3:0]        state;
  logic              in_flight;
  logic              have_byte;
  logic [1:0]        fetch_wait;
  logic [7:0]        data_byte;
  logic [CNT_W-1:0]  byte_cnt;
  logic [POLL_W-1:0] poll_left;
  logic [31:0]       addr_q;
  logic [16:0]       base_q;
  logic [7:0]        cmd_byte;
  logic [7:0]        tx_byte;
  logic              tx_ready;

  always_comb begin
    cmd_byte = 8'hFF;
    case (byte_cnt[2:0])
      3'd0:    cmd_byte = 8'h58;
      3'd1:    cmd_byte = addr_q[31:24];
      3'd2:    cmd_byte = addr_q[23:16];
      3'd3:    cmd_byte = addr_q[15:8];
      3'd4:    cmd_byte = addr_q[7:0];
      default: cmd_byte = 8'hFF;
    endcase
  end

  always_comb begin
    tx_byte = 8'hFF;
    case (state)
      S_CMD:   tx_byte = cmd_byte;
      S_TOKEN: tx_byte = 8'hFE;
      S_DATA:  tx_byte = data_byte;
      default: tx_byte = 8'hFF;
    endcase
  end

  // A data byte may only go out once its frame-buffer read has landed.
  assign tx_ready = (state != S_IDLE) && !in_flight && (state != S_DATA || have_byte);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      in_flight       <= 1'b0;
      have_byte       <= 1'b0;
      fetch_wait      <= 2'd0;
      data_byte       <= 8'hFF;
      byte_cnt        <= '0;
      poll_left       <= '0;
      addr_q          <= 32'd0;
      base_q          <= 17'd0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.error       <= 1'b0;
      bus.err_code    <= 3'd0;
      bus.cs          <= 1'b1;
      bus.pixel_addr  <= 17'd0;
      bus.spi_start   <= 1'b0;
      bus.spi_data_in <= 8'hFF;
    end else begin
      bus.spi_start <= 1'b0;
      bus.done      <= 1'b0;

      // Frame-buffer read pipeline: address out, BRAM registers it, then capture.
      if (fetch_wait == 2'd1) begin
        data_byte <= bus.pixel_rd_data;
        have_byte <= 1'b1;
      end
      if (fetch_wait != 2'd0) fetch_wait <= fetch_wait - 2'd1;

      if (state == S_IDLE && bus.start) begin
        addr_q       <= bus.block_addr;
        base_q       <= bus.pixel_base;
        bus.error    <= 1'b0;
        bus.err_code <= 3'd0;
        bus.busy     <= 1'b1;
        bus.cs       <= 1'b0;
        byte_cnt     <= '0;
        in_flight    <= 1'b0;
        state        <= S_CMD;
      end

      if (tx_ready) begin
        bus.spi_start   <= 1'b1;
        bus.spi_data_in <= tx_byte;
        in_flight       <= 1'b1;
        if (state == S_DATA) begin
          have_byte <= 1'b0;
          if (byte_cnt != LAST_BYTE) begin
            bus.pixel_addr <= bus.pixel_addr + 17'd1;
            fetch_wait     <= 2'd2;
          end
        end
      end

      if (in_flight && bus.spi_done) begin
        in_flight <= 1'b0;
        case (state)
          S_CMD: begin
            if (byte_cnt == CNT_W'(5)) begin
              byte_cnt  <= '0;
              poll_left <= POLL_W'(R1_POLLS);
              state     <= S_R1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_R1: begin
            if (bus.spi_data_out == 8'h00) begin
              state <= S_GAP;
            end else if (bus.spi_data_out != 8'hFF) begin
              state <= S_FAIL; bus.cs <= 1'b1; bus.err_code <= 3'd1;
            end else if (poll_left == POLL_W'(1)) begin
              state <= S_FAIL; bus.cs <= 1'b1; bus.err_code <= 3'd2;
            end else begin
              poll_left <= poll_left - 1'b1;
            end
          end
          S_GAP: begin
            bus.pixel_addr <= base_q;
            fetch_wait     <= 2'd2;
            have_byte      <= 1'b0;
            state          <= S_TOKEN;
          end
          S_TOKEN: begin
            byte_cnt <= '0;
            state    <= S_DATA;
          end
          S_DATA: begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= S_CRC;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_CRC: begin
            if (byte_cnt == CNT_W'(1)) begin
              poll_left <= POLL_W'(DRESP_POLLS);
              state     <= S_DRESP;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_DRESP: begin
            if (bus.spi_data_out != 8'hFF) begin
              if (bus.spi_data_out[4:0] == 5'b00101) begin
                poll_left <= POLL_W'(BUSY_POLLS);
                state     <= S_BUSYW;
              end else begin
                state <= S_FAIL; bus.cs <= 1'b1; bus.err_code <= 3'd3;
              end
            end else if (poll_left == POLL_W'(1)) begin
              state <= S_FAIL; bus.cs <= 1'b1; bus.err_code <= 3'd4;
            end else begin
              poll_left <= poll_left - 1'b1;
            end
          end
          S_BUSYW: begin
            if (bus.spi_data_out == 8'hFF) begin
              bus.cs <= 1'b1;
              state  <= S_FIN;
            end else if (poll_left == POLL_W'(1)) begin
              state <= S_FAIL; bus.cs <= 1'b1; bus.err_code <= 3'd5;
            end else begin
              poll_left <= poll_left - 1'b1;
            end
          end
          S_FIN: begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= S_IDLE;
          end
          S_FAIL: begin
            bus.error <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
